fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 29 ++
 rtl/fetch_sequencer_branch_resolve.sv | 29 ++
 rtl/fetch_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: sequencer states and branch-condition codes.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LWAIT = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_EQ     = 2'b01;
    localparam logic [1:0] COND_NE     = 2'b10;
    localparam logic [1:0] COND_LT     = 2'b11;

    function automatic logic cond_met(input logic [1:0] cond, input logic zero, input logic negative);
        logic met;
        met = 1'b0;
        case (cond)
            COND_ALWAYS: met = 1'b1;
            COND_EQ:     met = zero;
            COND_NE:     met = !zero;
            COND_LT:     met = negative;
            default:     met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/fetch_sequencer_branch_resolve.sv
// Combinational next-PC: sequential fall-through or taken branch (absolute / relative).
import fetch_sequencer_pkg::*;

module branch_resolve #(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    input  logic            cond_jump,
    input  logic            abs_or_rel,
    input  logic [1:0]      cond,
    input  logic            zero,
    input  logic            negative,
    output logic [PC_W-1:0] next_pc
);

    localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic taken;

    // Relative targets are two's complement; the PC_W-bit add wraps naturally.
    always_comb begin
        taken   = cond_jump && cond_met(cond, zero, negative);
        next_pc = pc + ONE;
        if (taken)
            next_pc = abs_or_rel ? (pc + target) : target;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE/RUN/LWAIT/HALT control with commit strobe.
// Optional executed-cycle counter enabled by defining CYCLE_COUNT_EN.
import fetch_sequencer_pkg::*;

module fetch_sequencer #(
    parameter int          PC_W       = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Ack,
    input  logic            ConditionalJump,
    input  logic            BranchAbsOrRel,
    input  logic [1:0]      BranchConditions,
    input  logic            LoadInst,
    input  logic            Zero,
    input  logic            Negative,
    input  logic [PC_W-1:0] Target,
    output logic [PC_W-1:0] ProgCtr,
    output logic            ExecEn,
    output logic            Done,
    output logic [15:0]     CycleCount
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] ONE      = {{(PC_W-1){1'b0}}, 1'b1};

    seq_state_t      state;
    logic            armed;
    logic [PC_W-1:0] next_pc;

    branch_resolve #(.PC_W(PC_W)) u_branch_resolve (
        .pc         (ProgCtr),
        .target     (Target),
        .cond_jump  (ConditionalJump),
        .abs_or_rel (BranchAbsOrRel),
        .cond       (BranchConditions),
        .zero       (Zero),
        .negative   (Negative),
        .next_pc    (next_pc)
    );

    // Reset forces IDLE asynchronously, so the strobe is low throughout reset.
    assign ExecEn = ((state == RUN) && !LoadInst) || (state == LWAIT);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            ProgCtr <= START_PC;
            Done    <= 1'b0;
            armed   <= 1'b0;
        end else if (Start) begin
            state   <= IDLE;
            ProgCtr <= START_PC;
            Done    <= 1'b0;
            armed   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (armed) begin
                        state <= RUN;
                        armed <= 1'b0;
                    end
                end
                RUN: begin
                    if (Ack) begin
                        state <= HALT;
                        Done  <= 1'b1;
                    end else if (LoadInst) begin
                        state <= LWAIT;
                    end else begin
                        ProgCtr <= next_pc;
                    end
                end
                LWAIT: begin
                    ProgCtr <= ProgCtr + ONE;
                    state   <= RUN;
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [15:0] cycle_cnt;

    // Cleared on the IDLE->RUN launch, saturating while active, frozen otherwise.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            cycle_cnt <= 16'h0000;
        else if (state == RUN || state == LWAIT) begin
            if (cycle_cnt != 16'hFFFF)
                cycle_cnt <= cycle_cnt + 16'h0001;
        end else if (state == IDLE && !Start && armed)
            cycle_cnt <= 16'h0000;
    end

    assign CycleCount = cycle_cnt;
`else
    assign CycleCount = 16'h0000;
`endif

endmodule
